// File: rtl/pc_branch_unit_pkg.sv
// Shared constants for the program-counter / branch stage of the 16-bit core.
package pc_branch_unit_pkg;

  localparam int unsigned WIDTH = 16;
  localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_type_e;

endpackage : pc_branch_unit_pkg

// File: rtl/pc_branch_unit_branch_cond_eval.sv
// Combinational branch-condition evaluation from the ALU flags of a subtract.
module branch_cond_eval
  import pc_branch_unit_pkg::*;
(
  input  logic [1:0] BranchType,
  input  logic       alu_zero,
  input  logic       alu_neg,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    unique case (br_type_e'(BranchType))
      BR_EQ:   cond_true = alu_zero;
      BR_NE:   cond_true = !alu_zero;
      BR_LT:   cond_true = alu_neg;
      BR_GE:   cond_true = !alu_neg;
      default: cond_true = 1'b0;
    endcase
  end

endmodule : branch_cond_eval

// File: rtl/pc_branch_unit.sv
// PC stage: holds PC, OldPC and the branch target, resolves conditional
// branches and flags misaligned PC loads.
module pc_branch_unit #(
  parameter int unsigned      WIDTH    = pc_branch_unit_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(pc_branch_unit_pkg::RESET_PC)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             PCSrc,
  input  logic             Branch,
  input  logic [1:0]       BranchType,
  input  logic             IRWrite,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] old_pc,
  output logic [WIDTH-1:0] branch_target,
  output logic             branch_taken,
  output logic             misalign_err,
  output logic [WIDTH-1:0] instr_count
);

  logic             cond_true;
  logic             pc_load_c;
  logic             taken_c;
  logic [WIDTH-1:0] pc_next_c;

  branch_cond_eval u_cond (
    .BranchType (BranchType),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .cond_true  (cond_true)
  );

  // PC source select; a not-taken conditional branch performs no load at all
  always_comb begin
    pc_load_c = 1'b0;
    taken_c   = 1'b0;
    pc_next_c = alu_result;
    if (PCWrite) begin
      if (PCSrc) begin
        pc_next_c = branch_target;
        if (Branch) begin
          pc_load_c = cond_true;
          taken_c   = cond_true;
        end else begin
          pc_load_c = 1'b1;
        end
      end else begin
        pc_load_c = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc            <= RESET_PC;
      old_pc        <= '0;
      branch_target <= '0;
      branch_taken  <= 1'b0;
      misalign_err  <= 1'b0;
      instr_count   <= '0;
    end else begin
      branch_taken <= taken_c;
      if (pc_load_c) begin
        pc <= {pc_next_c[WIDTH-1:1], 1'b0};
        if (pc_next_c[0]) misalign_err <= 1'b1;
      end
      // old_pc samples the pre-update PC of the fetch cycle
      if (IRWrite) begin
        old_pc      <= pc;
        instr_count <= instr_count + WIDTH'(1);
      end
      if (Branch && !PCWrite) branch_target <= alu_result;
    end
  end

endmodule : pc_branch_unit

// File: tb/tb_pc_branch_unit.sv
// Directed scoreboard bench for pc_branch_unit: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_pc_branch_unit;

  logic        CLK;
  logic        Reset;
  logic        PCWrite, PCSrc, Branch, IRWrite, alu_zero, alu_neg;
  logic [1:0]  BranchType;
  logic [15:0] alu_result;
  logic [15:0] pc, old_pc, branch_target, instr_count;
  logic        branch_taken, misalign_err;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] old_pc;
    logic [15:0] tgt;
    logic        tk;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_m  = 16'h0000;

  pc_branch_unit dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .PCWrite       (PCWrite),
    .PCSrc         (PCSrc),
    .Branch        (Branch),
    .BranchType    (BranchType),
    .IRWrite       (IRWrite),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_neg       (alu_neg),
    .pc            (pc),
    .old_pc        (old_pc),
    .branch_target (branch_target),
    .branch_taken  (branch_taken),
    .misalign_err  (misalign_err),
    .instr_count   (instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare whenever an expectation is pending
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("old_pc", old_pc, e.old_pc);
        chk("branch_target", branch_target, e.tgt);
        chk("branch_taken", {15'd0, branch_taken}, {15'd0, e.tk});
        chk("misalign_err", {15'd0, misalign_err}, {15'd0, e.mis});
        chk("instr_count", instr_count, e.cnt);
      end
    end
  end

  task automatic drive(input logic pcw, pcs, br, input logic [1:0] bt, input logic irw,
                       input logic [15:0] alu, input logic z, n);
    PCWrite = pcw; PCSrc = pcs; Branch = br; BranchType = bt;
    IRWrite = irw; alu_result = alu; alu_zero = z; alu_neg = n;
  endtask

  task automatic step(input logic pcw, pcs, br, input logic [1:0] bt, input logic irw,
                      input logic [15:0] alu, input logic z, n,
                      input logic [15:0] e_pc, e_old, e_tgt, input logic e_tk, e_mis);
    exp_t e;
    @(negedge CLK);
    drive(pcw, pcs, br, bt, irw, alu, z, n);
    @(posedge CLK);
    #1;
    if (irw) cnt_m = cnt_m + 16'd1;
    e = '{pc: e_pc, old_pc: e_old, tgt: e_tgt, tk: e_tk, mis: e_mis, cnt: cnt_m};
    q.push_back(e);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge
  task automatic async_reset();
    exp_t e;
    @(negedge CLK);
    drive(0, 0, 0, 2'b00, 0, 16'h0000, 0, 0);
    @(posedge CLK);
    #2;
    Reset = 1'b1;
    cnt_m = 16'h0000;
    e = '{pc: 16'h0000, old_pc: 16'h0000, tgt: 16'h0000, tk: 1'b0, mis: 1'b0, cnt: 16'h0000};
    q.push_back(e);
    @(negedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, p;
    exp_t e;
    Reset = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 16'h0000, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    e = '{pc: 16'h0000, old_pc: 16'h0000, tgt: 16'h0000, tk: 1'b0, mis: 1'b0, cnt: 16'h0000};
    q.push_back(e);
    @(negedge CLK);
    #1;
    Reset = 1'b0;

    //   pcw pcs br bt     irw alu       z  n   pc        old       tgt       tk mis
    step(1, 0, 0, 2'b00, 0, 16'h0010, 0, 0,  16'h0010, 16'h0000, 16'h0000, 0, 0);
    step(1, 0, 0, 2'b00, 1, 16'h0012, 0, 0,  16'h0012, 16'h0010, 16'h0000, 0, 0);
    step(0, 0, 1, 2'b00, 0, 16'h0030, 0, 0,  16'h0012, 16'h0010, 16'h0030, 0, 0);
    step(1, 1, 1, 2'b00, 0, 16'h0099, 1, 0,  16'h0030, 16'h0010, 16'h0030, 1, 0);
    step(0, 0, 0, 2'b00, 0, 16'h0000, 0, 0,  16'h0030, 16'h0010, 16'h0030, 0, 0);
    step(0, 0, 1, 2'b00, 0, 16'h0050, 0, 0,  16'h0030, 16'h0010, 16'h0050, 0, 0);
    step(1, 1, 1, 2'b11, 0, 16'h0000, 0, 1,  16'h0030, 16'h0010, 16'h0050, 0, 0);
    step(1, 1, 1, 2'b10, 0, 16'h0000, 0, 1,  16'h0050, 16'h0010, 16'h0050, 1, 0);
    step(1, 1, 1, 2'b01, 0, 16'h0000, 1, 0,  16'h0050, 16'h0010, 16'h0050, 0, 0);
    step(0, 0, 1, 2'b00, 0, 16'h0060, 0, 0,  16'h0050, 16'h0010, 16'h0060, 0, 0);
    step(1, 1, 1, 2'b01, 0, 16'h0000, 0, 0,  16'h0060, 16'h0010, 16'h0060, 1, 0);
    step(1, 1, 1, 2'b00, 0, 16'h0000, 0, 0,  16'h0060, 16'h0010, 16'h0060, 0, 0);
    step(1, 0, 0, 2'b00, 0, 16'h0100, 0, 0,  16'h0100, 16'h0010, 16'h0060, 0, 0);
    step(1, 1, 0, 2'b00, 0, 16'h0000, 0, 0,  16'h0060, 16'h0010, 16'h0060, 0, 0);
    // RITYPE-style Branch with PCWrite=0 only touches the target
    step(0, 0, 1, 2'b00, 0, 16'h0200, 1, 0,  16'h0060, 16'h0010, 16'h0200, 0, 0);
    step(1, 0, 1, 2'b00, 0, 16'h0070, 1, 0,  16'h0070, 16'h0010, 16'h0200, 0, 0);
    // odd load: forced even, sticky error
    step(1, 0, 0, 2'b00, 0, 16'h0023, 0, 0,  16'h0022, 16'h0010, 16'h0200, 0, 1);
    p = 16'h0022;
    for (int i = 0; i < 10; i++) begin
      a = 16'h0024 + 16'(2 * i);
      step(1, 0, 0, 2'b00, 1, a, 0, 0,  a, p, 16'h0200, 0, 1);
      p = a;
    end
    step(0, 0, 1, 2'b00, 0, 16'h0041, 0, 0,  16'h0036, 16'h0034, 16'h0041, 0, 1);
    step(1, 1, 1, 2'b00, 0, 16'h0000, 1, 0,  16'h0040, 16'h0034, 16'h0041, 1, 1);

    async_reset();

    // not-taken branch to an odd target performs no load and sets no error
    step(0, 0, 1, 2'b00, 0, 16'h0041, 0, 0,  16'h0000, 16'h0000, 16'h0041, 0, 0);
    step(1, 1, 1, 2'b01, 0, 16'h0000, 1, 0,  16'h0000, 16'h0000, 16'h0041, 0, 0);
    step(1, 0, 0, 2'b00, 0, 16'hFFFE, 0, 0,  16'hFFFE, 16'h0000, 16'h0041, 0, 0);
    step(1, 0, 0, 2'b00, 1, 16'h0000, 0, 0,  16'h0000, 16'hFFFE, 16'h0041, 0, 0);

    // run instr_count up to FFFE unchecked, then check FFFF and the wrap
    for (int i = 0; i < 32'h0000_FFFD; i++) begin
      @(negedge CLK);
      drive(0, 0, 0, 2'b00, 1, 16'h0000, 0, 0);
      cnt_m = cnt_m + 16'd1;
    end
    step(0, 0, 0, 2'b00, 1, 16'h0000, 0, 0,  16'h0000, 16'h0000, 16'h0041, 0, 0);
    step(0, 0, 0, 2'b00, 1, 16'h0000, 0, 0,  16'h0000, 16'h0000, 16'h0041, 0, 0);
    step(0, 0, 0, 2'b00, 0, 16'h0000, 0, 0,  16'h0000, 16'h0000, 16'h0041, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_branch_unit

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter stage of the 16-bit multi-cycle core, directly downstream of the control FSM.
- Consumes the FSM's PCWrite, PCSrc, Branch, BranchType and IRWrite strobes together with the ALU result and flags.
- Holds PC, OldPC (the PC of the instruction in IR) and the latched branch target.
- Resolves conditional branches and feeds the address to the IoD mux and the ALU A-source mux.

Parameters:
- WIDTH, 16, datapath/address width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- PCWrite  in  1  PC write enable from control.
- PCSrc  in  1  0 = PC from alu_result, 1 = PC from branch target register.
- Branch  in  1  branch-phase qualifier from control.
- BranchType  in  2  00 beq, 01 bne, 10 blt, 11 bge.
- IRWrite  in  1  instruction-fetch strobe; captures OldPC.
- alu_result  in  WIDTH  ALU output.
- alu_zero  in  1  ALU result == 0.
- alu_neg  in  1  ALU result sign bit (signed compare, subtract).
- pc  out  WIDTH  current PC.
- old_pc  out  WIDTH  PC of the instruction currently held in IR.
- branch_target  out  WIDTH  latched target address.
- branch_taken  out  1  one-cycle pulse, registered, when a conditional branch redirects PC.
- misalign_err  out  1  sticky; set on an attempted odd PC write.
- instr_count  out  WIDTH  count of IRWrite pulses, wraps.

Behaviour:
- Reset (async, any cycle, including mid-branch):
  - pc = RESET_PC.
  - old_pc, branch_target and instr_count = 0.
  - branch_taken and misalign_err = 0.
  - Outputs hold their values while Reset is high.
- All state updates occur on the CLK rising edge. There is no combinational path from inputs to outputs.
- OldPC and instruction count:
  - IRWrite=1: old_pc <= pc (the value before any same-cycle PC update).
  - IRWrite=1: instr_count <= instr_count+1, wrapping FFFF -> 0000.
- Target latch:
  - Branch=1 and PCWrite=0: branch_target <= alu_result.
  - This covers both the BRANCH cycle and the RITYPE cycle, which also asserts Branch. The RITYPE write is harmless and must not alter pc.
- PC update, with priority in listed order:
  1. PCWrite=1, PCSrc=1, Branch=1 (BRANCH2 cycle): evaluate the condition from the alu_zero and alu_neg inputs of this cycle.
     - beq: zero. bne: !zero. blt: neg. bge: !neg.
     - Taken: pc <= branch_target, and branch_taken = 1 next cycle.
     - Not taken: pc unchanged, and branch_taken = 0.
  2. PCWrite=1, PCSrc=1, Branch=0: pc <= branch_target, unconditionally. branch_taken stays 0.
  3. PCWrite=1, PCSrc=0 (fetch PC+2, JAL): pc <= alu_result, regardless of Branch.
  4. PCWrite=0: pc holds.
- branch_taken is high for exactly one cycle and clears on any subsequent edge.
- Alignment:
  - Any PC load whose bit 0 is 1 loads the value with bit 0 forced to 0.
  - The same load sets misalign_err.
  - misalign_err is cleared only by Reset.
  - A not-taken branch performs no load, so it never sets the flag.
- Simultaneous events:
  - IRWrite with PCWrite (the fetch cycle): old_pc gets the old pc, and pc gets alu_result.
  - Branch=1 with PCWrite=1 does not update branch_target.
- Wrap-around: the PC is not saturated. A load of FFFE followed by a +2 yields 0000 with no error.
- Latency:
  - The PC change is visible 1 cycle after the strobe.
  - The branch decision uses the flags in the same cycle as the strobe, with no extra stall.

Decomposition:
- Shared package (e.g. lime_pkg):
  - WIDTH.
  - Branch-type constants BR_EQ=2'b00, BR_NE=2'b01, BR_LT=2'b10, BR_GE=2'b11.
  - RESET_PC default.
- One natural sub-module: branch_cond_eval.
  - Purely combinational.
  - Inputs: BranchType, alu_zero, alu_neg.
  - Output: cond_true.
  - Reused by any future branch-prediction or trace logic.

Test Plan:
- Reset: assert Reset mid-cycle with pc=0x0040 -> pc=0x0000, old_pc=0, instr_count=0, misalign_err=0, all immediately (asynchronous).
- Fetch: pc=0x0010, alu_result=0x0012, PCWrite=1, PCSrc=0, IRWrite=1 -> next cycle pc=0x0012, old_pc=0x0010, instr_count+1.
- beq taken:
  - Cycle 1: Branch=1, PCWrite=0, alu_result=0x0030 -> branch_target=0x0030.
  - Cycle 2: Branch=1, PCSrc=1, PCWrite=1, BranchType=00, alu_zero=1 -> pc=0x0030 and branch_taken pulses for 1 cycle.
- bge not taken: target=0x0050, BranchType=11, alu_neg=1 -> pc unchanged and branch_taken=0. Repeat with blt, alu_neg=1 -> pc=0x0050.
- Misaligned load: PCWrite=1, PCSrc=0, alu_result=0x0023 -> pc=0x0022, misalign_err=1, still 1 after 10 more fetches, cleared only by Reset.
- Wrap:
  - pc=0xFFFE, fetch with alu_result=0x0000 -> pc=0x0000, no error.
  - instr_count preset to 0xFFFF by 65535 IRWrite pulses, one more pulse -> instr_count=0x0000.
